// File: rtl/gray_pkg.sv
// Shared constants and helpers for the Gray-code counter.
package gray_pkg;

    localparam int unsigned DEFAULT_WIDTH = 4;
    localparam int unsigned MAX_WIDTH     = 32;

    // Callers zero-extend into MAX_WIDTH and truncate the result back to their width.
    function automatic logic [MAX_WIDTH-1:0] gray_encode(input logic [MAX_WIDTH-1:0] i_bin);
        return i_bin ^ (i_bin >> 1);
    endfunction

endpackage

// File: rtl/gray_counter_if.sv
// Control/preset inputs and registered count outputs of gray_counter.
interface gray_counter_if #(
    parameter int unsigned WIDTH = gray_pkg::DEFAULT_WIDTH
);

    logic             EN;
    logic             UP;
    logic             LOAD;
    logic [WIDTH-1:0] G_LOAD;
    logic [WIDTH-1:0] G_OUT;
    logic [WIDTH-1:0] B_OUT;
    logic             WRAP;

    modport master (
        output EN, UP, LOAD, G_LOAD,
        input  G_OUT, B_OUT, WRAP
    );

    modport slave (
        input  EN, UP, LOAD, G_LOAD,
        output G_OUT, B_OUT, WRAP
    );

endinterface

// File: rtl/gray_decode.sv
// Combinational Gray-to-binary decode: each binary bit is the XOR of all Gray bits at or above it.
module gray_decode #(
    parameter int unsigned WIDTH = gray_pkg::DEFAULT_WIDTH
) (
    input  logic [WIDTH-1:0] i_gray,
    output logic [WIDTH-1:0] o_bin
);

    always_comb begin
        o_bin = '0;
        for (int i = 0; i < WIDTH; i++) begin
            o_bin[i] = ^(i_gray >> i);
        end
    end

endmodule

// File: rtl/gray_counter.sv
// Up/down counter held in binary, with registered Gray, binary and wrap-pulse outputs.
module gray_counter
    import gray_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
    input  logic           CLK,
    input  logic           RST,
    gray_counter_if.slave  bus
);

    logic [WIDTH-1:0] r_bin;
    logic [WIDTH-1:0] r_gray;
    logic             r_wrap;

    logic [WIDTH-1:0] w_load_bin;
    logic [WIDTH-1:0] w_bin_next;
    logic [WIDTH-1:0] w_gray_next;
    logic             w_wrap_next;

    gray_decode #(
        .WIDTH (WIDTH)
    ) u_load_decode (
        .i_gray (bus.G_LOAD),
        .o_bin  (w_load_bin)
    );

    // LOAD wins over EN; wrap is detected from the pre-step value.
    always_comb begin
        w_bin_next  = r_bin;
        w_wrap_next = 1'b0;
        if (bus.LOAD) begin
            w_bin_next = w_load_bin;
        end else if (bus.EN) begin
            if (bus.UP) begin
                w_bin_next  = r_bin + WIDTH'(1);
                w_wrap_next = &r_bin;
            end else begin
                w_bin_next  = r_bin - WIDTH'(1);
                w_wrap_next = ~|r_bin;
            end
        end
    end

    assign w_gray_next = WIDTH'(gray_encode(MAX_WIDTH'(w_bin_next)));

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_bin  <= '0;
            r_gray <= '0;
            r_wrap <= 1'b0;
        end else begin
            r_bin  <= w_bin_next;
            r_gray <= w_gray_next;
            r_wrap <= w_wrap_next;
        end
    end

    assign bus.G_OUT = r_gray;
    assign bus.B_OUT = r_bin;
    assign bus.WRAP  = r_wrap;

endmodule

// File: doc/gray_counter.md
GRAY_COUNTER -- requirements
Module: gray_counter

Interface
REQ-001 SHALL have parameter: WIDTH, 4, counter width in bits (min 2).
REQ-002 SHALL have port: CLK  input  1  sole clock, all state updates on rising edge.
REQ-003 SHALL have port: RST  input  1  reset, synchronous and active-high.
REQ-004 SHALL have port: EN  input  1  count enable, advance one step per cycle when high.
REQ-005 SHALL have port: UP  input  1  direction, 1 = increment, 0 = decrement.
REQ-006 SHALL have port: LOAD  input  1  synchronous load strobe.
REQ-007 SHALL have port: G_LOAD  input  WIDTH  Gray-coded preset value.
REQ-008 SHALL have port: G_OUT  output  WIDTH  registered Gray-coded count, drives downstream Gray-to-binary decode.
REQ-009 SHALL have port: B_OUT  output  WIDTH  registered binary equivalent of G_OUT, same cycle.
REQ-010 SHALL have port: WRAP  output  1  registered one-cycle wrap pulse.

Function
REQ-011 SHALL hold the count internally in binary, and SHALL register G_OUT = next_bin ^ (next_bin >> 1).
REQ-012 SHALL update G_OUT, B_OUT and WRAP on the same edge (latency 1 cycle from EN/LOAD).
REQ-013 SHALL apply priority RST > LOAD > EN > hold.
REQ-014 On LOAD=1, SHALL decode G_LOAD to binary (b[MSB]=g[MSB]; b[i]=b[i+1]^g[i]) and register it, ignoring EN and UP.
REQ-015 On LOAD=1, SHALL drive WRAP=0 next cycle.
REQ-016 On EN=1, UP=1, SHALL increment binary count modulo 2^WIDTH.
REQ-017 On EN=1, UP=0, SHALL decrement binary count modulo 2^WIDTH.
REQ-018 SHALL assert WRAP for exactly one cycle after an increment from 2^WIDTH-1 to 0, or a decrement from 0 to 2^WIDTH-1.
REQ-019 SHALL otherwise drive WRAP=0.
REQ-020 SHALL change exactly one bit of G_OUT per enabled count step, including across wrap.
REQ-021 With EN=0 and LOAD=0, SHALL hold G_OUT and B_OUT and drive WRAP=0.
REQ-022 SHALL sample UP on every enabled cycle; direction may change cycle-to-cycle with no dead cycle.
REQ-023 SHALL accept any G_LOAD value as legal (all 2^WIDTH codes valid).

Reset
REQ-024 While RST=1 at a rising CLK edge, SHALL force the count to 0: G_OUT=0, B_OUT=0, WRAP=0.
REQ-025 RST SHALL override LOAD and EN in the same cycle; counting SHALL resume from 0 on the first edge with RST=0.
REQ-026 RST asserted mid-count SHALL take effect on that edge with no partial update.

Structure
REQ-027 SHALL place the default WIDTH constant and a Gray-encode function (bin ^ bin>>1) in shared package gray_pkg.
REQ-028 SHALL use one combinational sub-module, gray_decode (WIDTH-parameterised Gray-to-binary), for the G_LOAD path.
REQ-029 SHALL contain one sequential process for the count and WRAP registers only.

Verification (WIDTH=4)
REQ-030 RST=1 for 2 cycles, then RST=0, EN=0 -> G_OUT=0000, B_OUT=0000, WRAP=0 held.
REQ-031 EN=1, UP=1 for 16 cycles -> G_OUT 0000,0001,0011,0010,0110,0111,0101,0100,1100,1101,1111,1110,1010,1011,1001,1000,0000; WRAP=1 only on the 1000->0000 cycle; one bit changes per step.
REQ-032 LOAD=1, G_LOAD=0110, EN=1 -> next G_OUT=0110, B_OUT=0100, WRAP=0; then UP=0, EN=1 -> G_OUT=0010, B_OUT=0011.
REQ-033 From 0000, EN=1, UP=0 -> G_OUT=1000, B_OUT=1111, WRAP=1 for one cycle.
REQ-034 Count to B_OUT=0101, assert RST with EN=1 and LOAD=1 -> next G_OUT=0000, WRAP=0; release RST -> G_OUT=0001.
REQ-035 Feed G_OUT each cycle into the downstream Gray-to-binary decoder -> decoded value equals B_OUT in every cycle of scenarios REQ-031 to REQ-034.
